// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter block.
package counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Width used by clamp_load; covers the widest legal counter.
  localparam int CLAMP_W = 16;

  // Limit a load value to the highest legal count.
  function automatic logic [CLAMP_W-1:0] clamp_load(input logic [CLAMP_W-1:0] value,
                                                    input logic [CLAMP_W-1:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control and status bundle between the tile top level and the counter.
interface mod_updown_counter_if #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 8
);
  logic             en;
  logic             dir;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [PRE_W-1:0] div;
  logic             clr_flag;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap_flag;

  // Controller side: drives controls, observes status.
  modport master (
    output en, dir, sat_mode, load, load_val, div, clr_flag,
    input  count, tc, wrap_flag
  );

  // Counter side: consumes controls, produces status.
  modport slave (
    input  en, dir, sat_mode, load, load_val, div, clr_flag,
    output count, tc, wrap_flag
  );
endinterface

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: one tick every div+1 enabled cycles.
module tick_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  localparam logic [PRE_W-1:0] ONE = PRE_W'(1);

  logic [PRE_W-1:0] pre_cnt_reg;
  logic [PRE_W-1:0] pre_cnt_next;

  // >= rather than == so that lowering div mid-period ticks at once
  // instead of running all the way around the counter.
  assign tick = en && (pre_cnt_reg >= div);

  // Phase update: clear restarts the period, tick wraps it, enable advances it.
  always_comb begin
    pre_cnt_next = pre_cnt_reg;
    if (clr) begin
      pre_cnt_next = '0;
    end else if (tick) begin
      pre_cnt_next = '0;
    end else if (en) begin
      pre_cnt_next = pre_cnt_reg + ONE;
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable modulus, wrap/saturate mode, load,
// prescaled stepping, terminal-count pulse and sticky wrap flag.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int PRE_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mod_updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic             tick;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             tc_reg;
  logic             tc_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic             wrap_set;
  logic             at_bound;
  logic [WIDTH-1:0] load_clamped;

  // A load also restarts the prescaler so the next step is a full period away.
  tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (bus.load),
    .div   (bus.div),
    .tick  (tick)
  );

  assign load_clamped = WIDTH'(clamp_load(CLAMP_W'(bus.load_val), CLAMP_W'(MAX_VAL)));

  // Next count: load beats step beats hold; bound handling depends on mode.
  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    wrap_set   = 1'b0;
    at_bound   = (bus.dir == DIR_UP) ? (count_reg == MAX_C) : (count_reg == '0);
    if (bus.load) begin
      count_next = load_clamped;
    end else if (tick) begin
      if (at_bound) begin
        tc_next = 1'b1;
        if (bus.sat_mode == MODE_WRAP) begin
          count_next = (bus.dir == DIR_UP) ? '0 : MAX_C;
          wrap_set   = 1'b1;
        end
      end else begin
        count_next = (bus.dir == DIR_UP) ? (count_reg + ONE) : (count_reg - ONE);
      end
    end
  end

  // A wrap in the same cycle as a clear leaves the flag set.
  assign wrap_next = wrap_set | (wrap_reg & ~bus.clr_flag);

  // Count, terminal-count and wrap-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      tc_reg    <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign bus.count     = count_reg;
  assign bus.tc        = tc_reg;
  assign bus.wrap_flag = wrap_reg;

endmodule
